shadow_dump_sequencer: RTL and testbench
========================================

// Module: shadow_dump_sequencer
// PURPOSE
//  Sequences one shadow-capture dump. On trigger: pulses capture to the shadow chains, then waits for the current block's ready.
//  Then shifts each block of CHAINS_OUT chains out bit-serially over a valid/ready stream, one block after another.
//  Sits between the shadow chains and the dump packer/host link; owns chain shift enables and block selection.
// PARAMETERS
//  CHAINS_IN   8     total shadow chains
//  CHAINS_OUT  2     chains shifted in parallel (stream width)
//  CHAIN_LEN   64    bits per chain (>=1)
//  LEN_W       6     bit-counter width, $clog2(CHAIN_LEN) (min 1)
//  BLK_W       8     block-index width, holds NUM_BLKS-1; NUM_BLKS = ceil(CHAINS_IN/CHAINS_OUT)
//  TIMEOUT     1024  max WAIT_READY cycles before error
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous, active-high reset
//  trigger    in   1           start a dump (sampled in IDLE only)
//  abort      in   1           cancel dump, return to IDLE
//  capture    out  1           1-cycle pulse to all shadow chains
//  cin_ready  in   CHAINS_IN   chain holds captured data (level)
//  cin        in   CHAINS_IN   serial head bit of each chain
//  shift_en   out  CHAINS_IN   advance chain by one bit
//  out_data   out  CHAINS_OUT  current beat, lane i = chain blk*CHAINS_OUT+i
//  out_valid  out  1           beat valid
//  out_ready  in   1           downstream accepts beat
//  out_last   out  1           final beat of current block
//  out_blk    out  BLK_W       block index of current beat
//  busy       out  1           state != IDLE
//  done       out  1           1-cycle pulse, dump finished
//  error      out  1           1-cycle pulse with done on timeout
// BEHAVIOUR
//  Reset: state IDLE, counters 0, ready mask 0; capture/out_valid/done/error/busy = 0; shift_en = 0.
//  Rst has priority over abort; abort over all other inputs.
//  FSM: IDLE -> CAPTURE -> WAIT_RDY -> SHIFT -> (next block: WAIT_RDY | last block: DONE) -> IDLE.
//  IDLE: trigger=1 -> CAPTURE next cycle. Trigger in any other state ignored (no queueing).
//  CAPTURE: capture=1 for exactly this cycle; clear sticky ready mask, bit_cnt, blk, timer.
//  Ready mask: ready_mask <= ready_mask | cin_ready each cycle outside CAPTURE.
//  WAIT_RDY: all in-range chains of block blk ready in ready_mask (or cin_ready this cycle) -> SHIFT.
//    timer counts; timer==TIMEOUT-1 without ready -> DONE with error.
//  SHIFT: out_valid=1; out_data combinational from cin of block blk.
//    Out-of-range lanes (index >= CHAINS_IN) read 0 and never get shift_en.
//    Beat accepted when out_valid & out_ready; on acceptance only, shift_en=1 for in-range chains of blk.
//    No acceptance -> hold: no shift, bit_cnt unchanged, out_data stable.
//    bit_cnt +1 per acceptance; out_last = (bit_cnt==CHAIN_LEN-1).
//    Accept with out_last: bit_cnt <= 0; blk==NUM_BLKS-1 -> DONE, else blk+1 and WAIT_RDY (timer cleared).
//  DONE: done=1 one cycle (error=1 too if timed out); -> IDLE. busy=0 from the IDLE cycle.
//  abort (any state): next state IDLE, no done pulse, counters cleared, shift_en=0 that cycle.
//  Latency: trigger@t -> capture@t+1.
//    All ready -> first out_valid@t+3 (WAIT_RDY@t+2, SHIFT@t+3).
//  Total beats = NUM_BLKS*CHAIN_LEN; bits/chain exactly CHAIN_LEN; no wrap of blk past NUM_BLKS-1.
//  capture, done, error and state/counters are registered. out_valid, out_last and out_blk decode registered state.
//  shift_en and out_data are combinational.
// STRUCTURE
//  Shared package shadow_pkg: state enum (IDLE,CAPTURE,WAIT_RDY,SHIFT,DONE), NUM_BLKS function,
//  clog2 helper. Reuses the existing dffr_ns/dffre_ns flops.
//  One sub-module: shadow_blk_mux (cin -> out_data lane select + range mask for shift_en).
// TESTING
//  Defaults, all cin_ready=1, out_ready=1, trigger@t -> capture@t+1, 256 beats, out_last every 64th, done once, error=0.
//  out_ready toggles 1/0 -> shift_en only on accepted beats; each chain shifted exactly 64 times; data order preserved.
//  CHAINS_IN=5,CHAINS_OUT=2 -> 3 blocks; block 2 lane1 reads 0; shift_en[5+] never exists; 3*64 beats.
//  cin_ready for block 1 never rises -> error+done pulse after 1024 WAIT_RDY cycles; busy drops next cycle.
//  abort mid-SHIFT block 1 -> IDLE next cycle, no done; new trigger restarts at blk 0, bit 0.
//  Trigger held high throughout the dump -> exactly one dump; rst mid-SHIFT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/shadow_dump_sequencer_pkg.sv
// Shared types and elaboration helpers for the shadow-capture dump sequencer.
package shadow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_RDY,
    SHIFT,
    DONE
  } state_t;

  // Bit width needed to hold value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int num_blks(input int chains_in, input int chains_out);
    return (chains_in + chains_out - 1) / chains_out;
  endfunction

endpackage

// File: rtl/shadow_dump_sequencer_if.sv
// Bit-serial dump stream: one beat carries one bit from each chain of the current block.
interface shadow_dump_sequencer_if #(
  parameter int CHAINS_OUT = 2,
  parameter int BLK_W      = 8
);

  logic [CHAINS_OUT-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [BLK_W-1:0]      out_blk;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_blk,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_blk,
    output out_ready
  );

endinterface

// File: rtl/shadow_dump_sequencer_blk_mux.sv
// Selects the serial head bits of the chains in block blk and flags which chains belong to it.
module shadow_blk_mux #(
  parameter int CHAINS_IN  = 8,
  parameter int CHAINS_OUT = 2,
  parameter int BLK_W      = 8
) (
  input  logic [CHAINS_IN-1:0]  cin,
  input  logic [BLK_W-1:0]      blk,
  output logic [CHAINS_OUT-1:0] lane_data,
  output logic [CHAINS_IN-1:0]  chain_mask
);

  int base;

  // Lanes whose chain index falls past CHAINS_IN never match a chain and stay 0.
  always_comb begin
    lane_data  = '0;
    chain_mask = '0;
    base       = int'(blk) * CHAINS_OUT;
    for (int j = 0; j < CHAINS_IN; j++) begin
      for (int i = 0; i < CHAINS_OUT; i++) begin
        if (j == base + i) begin
          lane_data[i]  = cin[j];
          chain_mask[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shadow_dump_sequencer.sv
// Capture-then-dump sequencer: pulses capture, waits for each block's chains, streams them bit-serially.
module shadow_dump_sequencer
  import shadow_pkg::*;
#(
  parameter int CHAINS_IN  = 8,
  parameter int CHAINS_OUT = 2,
  parameter int CHAIN_LEN  = 64,
  parameter int LEN_W      = 6,
  parameter int BLK_W      = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 abort,
  output logic                 capture,
  input  logic [CHAINS_IN-1:0] cin_ready,
  input  logic [CHAINS_IN-1:0] cin,
  output logic [CHAINS_IN-1:0] shift_en,
  shadow_dump_sequencer_if.master dump,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int NUM_BLKS = num_blks(CHAINS_IN, CHAINS_OUT);
  localparam int TMR_W    = clog2_min1(TIMEOUT);

  localparam logic [LEN_W-1:0] LAST_BIT = LEN_W'(CHAIN_LEN - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLKS - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

  state_t               state;
  logic [LEN_W-1:0]     bit_cnt;
  logic [BLK_W-1:0]     blk;
  logic [TMR_W-1:0]     timer;
  logic [CHAINS_IN-1:0] ready_mask;
  logic [CHAINS_IN-1:0] chain_mask;
  logic [CHAINS_OUT-1:0] lane_data;
  logic                 blk_ready;
  logic                 accept;

  shadow_blk_mux #(
    .CHAINS_IN  (CHAINS_IN),
    .CHAINS_OUT (CHAINS_OUT),
    .BLK_W      (BLK_W)
  ) u_blk_mux (
    .cin        (cin),
    .blk        (blk),
    .lane_data  (lane_data),
    .chain_mask (chain_mask)
  );

  // A chain counts as ready if it was seen ready since capture or is ready right now.
  assign blk_ready = &((ready_mask | cin_ready) | ~chain_mask);
  assign accept    = (state == SHIFT) && dump.out_ready;
  assign shift_en  = (accept && !abort && !rst) ? chain_mask : '0;

  assign dump.out_data  = lane_data;
  assign dump.out_valid = (state == SHIFT);
  assign dump.out_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign dump.out_blk   = blk;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      blk        <= '0;
      timer      <= '0;
      ready_mask <= '0;
      capture    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      capture <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;

      if (state == CAPTURE) ready_mask <= '0;
      else                  ready_mask <= ready_mask | cin_ready;

      if (abort) begin
        state   <= IDLE;
        bit_cnt <= '0;
        blk     <= '0;
        timer   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state   <= CAPTURE;
              capture <= 1'b1;
            end
          end
          CAPTURE: begin
            bit_cnt <= '0;
            blk     <= '0;
            timer   <= '0;
            state   <= WAIT_RDY;
          end
          WAIT_RDY: begin
            if (blk_ready) begin
              state <= SHIFT;
            end else if (timer == TMR_MAX) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SHIFT: begin
            // Without acceptance every counter holds so the beat stays stable.
            if (dump.out_ready) begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (blk == LAST_BLK) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  blk   <= blk + 1'b1;
                  timer <= '0;
                  state <= WAIT_RDY;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shadow_dump_sequencer.sv
// Scoreboard bench: an 8-chain and a 5-chain sequencer fed by modelled shadow chains.
module tb_shadow_dump_sequencer;

  localparam int LEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       trig_a = 1'b0, abort_a = 1'b0;
  logic       cap_a, busy_a, done_a, err_a;
  logic [7:0] crdy_a = 8'hFF, cin_a, sh_a;

  logic       trig_b = 1'b0;
  logic       cap_b, busy_b, done_b, err_b;
  logic [4:0] crdy_b = 5'h1F, cin_b, sh_b;

  shadow_dump_sequencer_if #(.CHAINS_OUT(2), .BLK_W(8)) dump_a ();
  shadow_dump_sequencer_if #(.CHAINS_OUT(2), .BLK_W(8)) dump_b ();

  shadow_dump_sequencer #(
    .CHAINS_IN(8), .CHAINS_OUT(2), .CHAIN_LEN(LEN), .LEN_W(6), .BLK_W(8), .TIMEOUT(1024)
  ) dut_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .abort(abort_a), .capture(cap_a),
    .cin_ready(crdy_a), .cin(cin_a), .shift_en(sh_a), .dump(dump_a),
    .busy(busy_a), .done(done_a), .error(err_a)
  );

  shadow_dump_sequencer #(
    .CHAINS_IN(5), .CHAINS_OUT(2), .CHAIN_LEN(LEN), .LEN_W(6), .BLK_W(8), .TIMEOUT(1024)
  ) dut_b (
    .clk(clk), .rst(rst), .trigger(trig_b), .abort(1'b0), .capture(cap_b),
    .cin_ready(crdy_b), .cin(cin_b), .shift_en(sh_b), .dump(dump_b),
    .busy(busy_b), .done(done_b), .error(err_b)
  );

  logic [63:0] pat [8];
  logic [5:0]  pos_a [8] = '{default: 6'd0};
  logic [5:0]  pos_b [5] = '{default: 6'd0};
  int          cnt_a [8] = '{default: 0};
  int          cnt_b [5] = '{default: 0};
  logic [7:0]  pend_sh_a = '0;
  logic [4:0]  pend_sh_b = '0;
  logic        pend_cap_a = 1'b0, pend_cap_b = 1'b0;

  logic [10:0] q_a [$];
  logic [10:0] q_b [$];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int beats_a = 0, lasts_a = 0, dones_a = 0, errs_a = 0, caps_a = 0, last_acc_a = 0, done_cyc_a = 0;
  int beats_b = 0, lasts_b = 0, dones_b = 0;

  // Chain model: head bit at the chain's current position, reloaded on capture.
  always_comb begin
    cin_a = '0;
    cin_b = '0;
    for (int j = 0; j < 8; j++) cin_a[j] = pat[j][pos_a[j]];
    for (int j = 0; j < 5; j++) cin_b[j] = pat[j][pos_b[j]];
  end

  always @(posedge clk) begin
    for (int j = 0; j < 8; j++) begin
      if (pend_cap_a) pos_a[j] <= '0;
      else if (pend_sh_a[j]) begin
        pos_a[j] <= pos_a[j] + 6'd1;
        cnt_a[j] <= cnt_a[j] + 1;
      end
    end
    for (int j = 0; j < 5; j++) begin
      if (pend_cap_b) pos_b[j] <= '0;
      else if (pend_sh_b[j]) begin
        pos_b[j] <= pos_b[j] + 6'd1;
        cnt_b[j] <= cnt_b[j] + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      pend_sh_a  = sh_a;
      pend_sh_b  = sh_b;
      pend_cap_a = cap_a;
      pend_cap_b = cap_b;
      if (cap_a) caps_a++;
      if (done_a) begin
        dones_a++;
        done_cyc_a = cyc;
        if (err_a) errs_a++;
      end
      if (done_b) dones_b++;
      if (dump_a.out_valid && dump_a.out_ready && !abort_a && !rst) begin
        exp = (q_a.size() > 0) ? q_a.pop_front() : 11'h7FF;
        checkOutput("beatA", {dump_a.out_blk, dump_a.out_last, dump_a.out_data}, exp);
        checkOutput("shiftA", sh_a, 32'd3 << (2 * exp[10:3]));
        beats_a++;
        last_acc_a = cyc;
        if (dump_a.out_last) lasts_a++;
      end else begin
        checkOutput("holdShiftA", sh_a, 0);
      end
      if (dump_b.out_valid && dump_b.out_ready && !rst) begin
        exp = (q_b.size() > 0) ? q_b.pop_front() : 11'h7FF;
        checkOutput("beatB", {dump_b.out_blk, dump_b.out_last, dump_b.out_data}, exp);
        checkOutput("shiftB", sh_b, (32'd3 << (2 * exp[10:3])) & 32'h1F);
        beats_b++;
        if (dump_b.out_last) lasts_b++;
      end else begin
        checkOutput("holdShiftB", sh_b, 0);
      end
    end
  endtask

  // Queue the full expected beat sequence, then pulse (or hold) trigger.
  task automatic applyStimulus(input int which, input int nblk, input bit hold);
    int nch;
    logic [1:0] d;
    nch = (which == 0) ? 8 : 5;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < LEN; k++) begin
        for (int i = 0; i < 2; i++) d[i] = (b * 2 + i < nch) ? pat[b * 2 + i][k] : 1'b0;
        if (which == 0) q_a.push_back({8'(b), k == LEN - 1, d});
        else            q_b.push_back({8'(b), k == LEN - 1, d});
      end
    end
    @(posedge clk); #1;
    if (which == 0) trig_a = 1'b1; else trig_b = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      trig_a = 1'b0;
      trig_b = 1'b0;
    end
  endtask

  task automatic waitDone(input int which, input bit toggle, input int budget);
    int d0;
    d0 = (which == 0) ? dones_a : dones_b;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (((which == 0) ? dones_a : dones_b) != d0) break;
      if (toggle) dump_a.out_ready = ~dump_a.out_ready;
    end
    trig_a = 1'b0;
    trig_b = 1'b0;
    dump_a.out_ready = 1'b1;
    checkOutput("doneSeen", ((which == 0) ? dones_a : dones_b) - d0, 1);
  endtask

  task automatic waitBeats(input int target);
    for (int i = 0; i < 1000 && beats_a < target; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("beatsReached", beats_a >= target, 1);
  endtask

  task automatic runTests();
    int b0, l0, e0, d0, c0;
    int base_a [8];
    int base_b [5];

    for (int j = 0; j < 8; j++) pat[j] = {$urandom, $urandom};
    dump_a.out_ready = 1'b1;
    dump_b.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstCapture", cap_a, 0);
    checkOutput("rstBusy", busy_a, 0);
    checkOutput("rstDone", {done_a, err_a}, 0);
    checkOutput("rstValid", dump_a.out_valid, 0);
    checkOutput("rstShift", sh_a, 0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] full dump with latency check");
    b0 = beats_a; l0 = lasts_a; e0 = errs_a;
    foreach (base_a[j]) base_a[j] = cnt_a[j];
    applyStimulus(0, 4, 0);
    @(negedge clk);
    checkOutput("latCapture", cap_a, 1);
    checkOutput("latValidC", dump_a.out_valid, 0);
    @(negedge clk);
    checkOutput("latCapturePulse", cap_a, 0);
    checkOutput("latValidW", dump_a.out_valid, 0);
    @(negedge clk);
    checkOutput("latValidS", dump_a.out_valid, 1);
    waitDone(0, 0, 3000);
    checkOutput("beatsFull", beats_a - b0, 4 * LEN);
    checkOutput("lastsFull", lasts_a - l0, 4);
    checkOutput("errFull", errs_a - e0, 0);
    for (int j = 0; j < 8; j++) checkOutput("chainShiftsA", cnt_a[j] - base_a[j], LEN);

    $display("[TB] out_ready toggling");
    b0 = beats_a;
    foreach (base_a[j]) base_a[j] = cnt_a[j];
    applyStimulus(0, 4, 0);
    waitDone(0, 1, 3000);
    checkOutput("beatsToggle", beats_a - b0, 4 * LEN);
    for (int j = 0; j < 8; j++) checkOutput("chainShiftsT", cnt_a[j] - base_a[j], LEN);

    $display("[TB] trigger held through dump");
    b0 = beats_a; c0 = caps_a; d0 = dones_a;
    applyStimulus(0, 4, 1);
    waitDone(0, 0, 3000);
    repeat (6) @(negedge clk);
    checkOutput("heldCaptures", caps_a - c0, 1);
    checkOutput("heldDones", dones_a - d0, 1);
    checkOutput("heldBeats", beats_a - b0, 4 * LEN);

    $display("[TB] five chains over three blocks");
    b0 = beats_b; l0 = lasts_b;
    foreach (base_b[j]) base_b[j] = cnt_b[j];
    applyStimulus(1, 3, 0);
    waitDone(1, 0, 3000);
    checkOutput("beatsB", beats_b - b0, 3 * LEN);
    checkOutput("lastsB", lasts_b - l0, 3);
    for (int j = 0; j < 5; j++) checkOutput("chainShiftsB", cnt_b[j] - base_b[j], LEN);

    $display("[TB] block 1 never ready");
    e0 = errs_a;
    crdy_a = 8'hF3;
    applyStimulus(0, 1, 0);
    waitDone(0, 0, 3000);
    checkOutput("timeoutErr", errs_a - e0, 1);
    checkOutput("timeoutGap", done_cyc_a - last_acc_a, 1025);
    @(negedge clk);
    checkOutput("timeoutBusy", busy_a, 0);
    crdy_a = 8'hFF;

    $display("[TB] abort in block 1");
    b0 = beats_a; d0 = dones_a;
    applyStimulus(0, 4, 0);
    waitBeats(b0 + LEN + 10);
    abort_a = 1'b1;
    @(negedge clk);
    checkOutput("abortShift", sh_a, 0);
    @(posedge clk); #1;
    abort_a = 1'b0;
    q_a.delete();
    @(negedge clk);
    checkOutput("abortBusy", busy_a, 0);
    checkOutput("abortValid", dump_a.out_valid, 0);
    repeat (5) @(negedge clk);
    checkOutput("abortNoDone", dones_a - d0, 0);
    b0 = beats_a;
    applyStimulus(0, 4, 0);
    waitDone(0, 0, 3000);
    checkOutput("restartBeats", beats_a - b0, 4 * LEN);

    $display("[TB] reset mid-shift");
    b0 = beats_a;
    applyStimulus(0, 4, 0);
    waitBeats(b0 + 20);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstMidOutputs", {cap_a, dump_a.out_valid, dump_a.out_last, done_a, err_a, busy_a}, 0);
    checkOutput("rstMidShift", sh_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    fork
      monitor();
      runTests();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
